// File: rtl/alu_writeback.sv
// alu_writeback: ALU enable handshake, in-order result FIFO to the regfile port, and BEQZ/JAL PC redirect.
package alu_writeback_pkg;
    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_ADDI,
        ALU_BEQZ,
        ALU_JAL
    } alu_instruction_t;
endpackage

module alu_writeback
    import alu_writeback_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int PC_W       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int DEPTH      = 3,
    parameter int LINK_INC   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    output logic                  issue_ready,
    input  alu_instruction_t      issue_instr,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [PC_W-1:0]       issue_pc,
    input  logic [DATA_W-1:0]     issue_imm,
    output logic                  alu_enable,
    input  logic [DATA_W-1:0]     alu_result,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  redirect_valid,
    output logic [PC_W-1:0]       redirect_pc
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);
    logic                  tag_v;
    alu_instruction_t      tag_instr;
    logic [REG_ADDR_W-1:0] tag_rd;
    logic [PC_W-1:0]       tag_pc;
    logic [DATA_W-1:0]     tag_imm;
    logic [REG_ADDR_W-1:0] mem_rd [DEPTH];
    logic [DATA_W-1:0]     mem_data [DEPTH];
    logic                  mem_nw [DEPTH];
    logic [PW-1:0]         wp, rp;
    logic [CW-1:0]         count;
    logic                  fire, push, pop, head_nw, is_jal, is_beqz, redir;
    logic [DATA_W-1:0]     push_data;
    logic [PC_W-1:0]       link_pc, target;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        issue_ready = !reset && (({1'b0, count} + (CW + 1)'(tag_v)) < DEPTH_C);
        fire        = issue_valid && issue_ready;
        alu_enable  = fire;
        push        = tag_v;
        is_jal      = tag_instr == ALU_JAL;
        is_beqz     = tag_instr == ALU_BEQZ;
        link_pc     = tag_pc + PC_W'(LINK_INC);
        push_data   = is_jal ? DATA_W'(link_pc) : alu_result;
        redir       = push && (is_jal || (is_beqz && alu_result == DATA_W'(1)));
        target      = is_jal ? PC_W'(alu_result) : tag_pc + PC_W'(tag_imm);
        head_nw     = mem_nw[rp];
        wb_valid    = !reset && count != '0 && !head_nw;
        pop         = count != '0 && (head_nw || wb_ready);
        wb_rd       = wb_valid ? mem_rd[rp] : '0;
        wb_data     = wb_valid ? mem_data[rp] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_v          <= 1'b0;
            wp             <= '0;
            rp             <= '0;
            count          <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            tag_v          <= fire;
            if (push) wp   <= inc(wp);
            if (pop) rp    <= inc(rp);
            count          <= count + CW'(push) - CW'(pop);
            redirect_valid <= redir;
            redirect_pc    <= redir ? target : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (fire) begin
            tag_instr <= issue_instr;
            tag_rd    <= issue_rd;
            tag_pc    <= issue_pc;
            tag_imm   <= issue_imm;
        end
        if (push) begin
            mem_rd[wp]   <= tag_rd;
            mem_data[wp] <= push_data;
            mem_nw[wp]   <= is_beqz || tag_rd == '0;
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(push && count == CW'(DEPTH)));
endmodule

// File: tb/tb_alu_writeback.sv
// tb_alu_writeback: directed vectors against hand-computed writes and redirects.
module tb_alu_writeback;
    import alu_writeback_pkg::*;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             issue_valid = 1'b0;
    logic             issue_ready;
    alu_instruction_t issue_instr = ALU_ADD;
    logic [4:0]       issue_rd = '0;
    logic [31:0]      issue_pc = '0;
    logic [31:0]      issue_imm = '0;
    logic             alu_enable;
    logic [31:0]      alu_result = '0;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [4:0]       wb_rd;
    logic [31:0]      wb_data;
    logic             redirect_valid;
    logic [31:0]      redirect_pc;
    logic [31:0]      res_in = '0;
    int               checks = 0;
    int               errors = 0;
    int               wbv_cnt = 0;
    int               cyc_n = 0;
    int               acc;
    wr_t              wr_q[$];
    logic [31:0]      rdr_q[$];

    alu_writeback dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_instr(issue_instr),
        .issue_rd(issue_rd), .issue_pc(issue_pc), .issue_imm(issue_imm),
        .alu_enable(alu_enable), .alu_result(alu_result),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (alu_enable) alu_result <= res_in;

    always @(negedge clk) begin
        cyc_n++;
        if (wb_valid) begin
            wbv_cnt++;
            if (wb_ready) wr_q.push_back('{wb_rd, wb_data, cyc_n});
        end
        if (redirect_valid) rdr_q.push_back(redirect_pc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        wr_q.delete();
        rdr_q.delete();
        wbv_cnt = 0;
    endtask

    task automatic drive(input alu_instruction_t op, input logic [4:0] rd,
                         input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] res);
        issue_valid = 1'b1;
        issue_instr = op;
        issue_rd    = rd;
        issue_pc    = pc;
        issue_imm   = imm;
        res_in      = res;
    endtask

    initial begin
        repeat (2) step();
        issue_valid = 1'b1;
        @(negedge clk);
        check("rst_ready", issue_ready, 0);
        check("rst_en", alu_enable, 0);
        check("rst_wbv", wb_valid, 0);
        check("rst_rv", redirect_valid, 0);
        step();
        reset = 1'b0;
        issue_valid = 1'b0;
        @(negedge clk);
        check("rst_ready_post", issue_ready, 1);
        check("rst_wb_rd", wb_rd, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_rpc", redirect_pc, 0);
        step();

        clear();
        wb_ready = 1'b1;
        drive(ALU_ADD, 3, 0, 0, 7);
        @(negedge clk);
        check("t1_en_n", alu_enable, 1);
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        check("t1_en_n1", alu_enable, 0);
        check("t1_wbv_n1", wb_valid, 0);
        step();
        @(negedge clk);
        check("t1_wbv_n2", wb_valid, 1);
        check("t1_rd", wb_rd, 3);
        check("t1_data", wb_data, 7);
        step();
        @(negedge clk);
        check("t1_wbv_n3", wb_valid, 0);
        step();
        check("t1_writes", wr_q.size(), 1);

        clear();
        for (int i = 0; i < 4; i++) begin
            drive(ALU_ADD, 5'(i + 1), 0, 0, 32'(10 + i));
            @(negedge clk);
            check("t2_ready", issue_ready, 1);
            step();
        end
        issue_valid = 1'b0;
        repeat (5) step();
        check("t2_writes", wr_q.size(), 4);
        for (int i = 0; i < 4 && i < wr_q.size(); i++) begin
            check("t2_rd", wr_q[i].rd, 64'(i + 1));
            check("t2_data", wr_q[i].data, 64'(10 + i));
            check("t2_cyc", wr_q[i].cyc - wr_q[0].cyc, 64'(i));
        end

        clear();
        wb_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(ALU_ADD, 5'(5 + acc), 0, 0, 32'(20 + acc));
            @(negedge clk);
            if (alu_enable) acc++;
            if (i >= 2) check("t3_hold", wb_data, 20);
            step();
        end
        issue_valid = 1'b0;
        check("t3_accepted", acc, 3);
        @(negedge clk);
        check("t3_ready", issue_ready, 0);
        check("t3_wbv", wb_valid, 1);
        check("t3_rd", wb_rd, 5);
        step();
        wb_ready = 1'b1;
        repeat (5) step();
        check("t3_writes", wr_q.size(), 3);
        for (int i = 0; i < 3 && i < wr_q.size(); i++) begin
            check("t3_wr_rd", wr_q[i].rd, 64'(5 + i));
            check("t3_wr_data", wr_q[i].data, 64'(20 + i));
        end
        @(negedge clk);
        check("t3_ready_back", issue_ready, 1);
        step();

        clear();
        drive(ALU_BEQZ, 2, 32'h40, 32'h10, 1);
        step();
        issue_valid = 1'b0;
        @(negedge clk);
        check("t4_rv_n1", redirect_valid, 0);
        step();
        @(negedge clk);
        check("t4_rv_n2", redirect_valid, 1);
        check("t4_rpc", redirect_pc, 32'h50);
        step();
        @(negedge clk);
        check("t4_rv_n3", redirect_valid, 0);
        step();
        check("t4_pulses", rdr_q.size(), 1);
        check("t4_wbv", wbv_cnt, 0);

        clear();
        drive(ALU_BEQZ, 2, 32'h40, 32'h10, 0);
        step();
        issue_valid = 1'b0;
        repeat (4) step();
        check("t4nt_pulses", rdr_q.size(), 0);
        check("t4nt_wbv", wbv_cnt, 0);

        clear();
        drive(ALU_JAL, 1, 32'h20, 0, 32'h80);
        step();
        issue_valid = 1'b0;
        step();
        @(negedge clk);
        check("t5_rv", redirect_valid, 1);
        check("t5_rpc", redirect_pc, 32'h80);
        check("t5_wbv", wb_valid, 1);
        check("t5_rd", wb_rd, 1);
        check("t5_data", wb_data, 32'h21);
        repeat (3) step();
        check("t5_writes", wr_q.size(), 1);
        check("t5_pulses", rdr_q.size(), 1);

        clear();
        drive(ALU_ADDI, 0, 0, 5, 5);
        step();
        issue_valid = 1'b0;
        repeat (4) step();
        check("t5_r0_wbv", wbv_cnt, 0);

        clear();
        wb_ready = 1'b0;
        drive(ALU_ADD, 1, 0, 0, 1);
        step();
        drive(ALU_ADD, 2, 0, 0, 2);
        step();
        drive(ALU_JAL, 3, 32'h30, 0, 32'h90);
        step();
        issue_valid = 1'b0;
        check("t6_count_pre", dut.count, 2);
        clear();
        reset = 1'b1;
        wb_ready = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clk);
        check("t6_ready", issue_ready, 1);
        check("t6_wbv", wb_valid, 0);
        check("t6_count", dut.count, 0);
        repeat (5) step();
        check("t6_writes", wr_q.size(), 0);
        check("t6_pulses", rdr_q.size(), 0);
        check("t6_wbv_cnt", wbv_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
